// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg
// Shared definitions for the interrupt controller:
//   state_t       - sequencer state encoding
//   VEC_ADDR      - address of the interrupt vector in memory
//   SEL_*         - mem_addr_sel encodings (stack push, stack pop, vector)
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_PUSH   = 3'd2,
        ST_VEC    = 3'd3,
        ST_JUMP   = 3'd4,
        ST_POP    = 3'd5,
        ST_RESUME = 3'd6
    } state_t;

    localparam logic [7:0] VEC_ADDR = 8'h01;

    localparam logic [1:0] SEL_PUSH = 2'd0;
    localparam logic [1:0] SEL_POP  = 2'd1;
    localparam logic [1:0] SEL_VEC  = 2'd2;

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if
// Stack/vector memory port of the interrupt controller.
//   mem_req      - request active (controller -> memory)
//   mem_we       - 1 = push (write), 0 = read
//   mem_addr_sel - address source: SP-push, SP-pop or VEC_ADDR
//   mem_wdata    - data written on push
//   mem_ack      - request completed (memory -> controller)
//   mem_rdata    - read data, valid with mem_ack
interface int_ctrl_if;

    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_addr_sel;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr_sel, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr_sel, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/int_ctrl_sync_edge.sv
// int_ctrl_sync_edge
// Two-flop synchronizer followed by a rising-edge detector.
//   clk  - clock
//   rst  - synchronous active-high reset, clears all flops
//   din  - asynchronous input
//   rise - one-cycle pulse on each synchronized 0->1 transition
module int_ctrl_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl
// Interrupt entry/exit sequencer: flushes the pipeline, pushes the return
// PC, fetches the vector and jumps; on RTI pops the PC and resumes.
//   clk, rst      - clock, synchronous active-high reset
//   intr_in       - asynchronous interrupt request (edge triggered)
//   rti_dec       - one-cycle RTI decode pulse
//   pc_ret        - return PC, latched at interrupt entry
//   bus           - stack/vector memory port (int_ctrl_if.master)
//   flush, stall  - pipeline control
//   pc_load(_val) - one-cycle PC override
//   copy_ccr      - CCR backup pulse, paste_ccr - CCR restore pulse
//   in_service    - handler active, further interrupts held pending
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | normal execution, watching for pending interrupt or RTI
// FLUSH     | flush pipeline, back up CCR, latch return PC
// PUSH      | write return PC to stack, wait for ack
// VEC       | read vector address, wait for ack
// JUMP      | load PC with vector target
// POP       | read return PC from stack, wait for ack
// RESUME    | load PC with popped value, restore CCR, leave service
module int_ctrl
    import int_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             intr_in,
    input  logic             rti_dec,
    input  logic [7:0]       pc_ret,
    int_ctrl_if.master       bus,
    output logic             flush,
    output logic             stall,
    output logic             pc_load,
    output logic [7:0]       pc_load_val,
    output logic             copy_ccr,
    output logic             paste_ccr,
    output logic             in_service
);

    state_t state;
    logic   intr_edge;
    logic   pending;

    int_ctrl_sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (intr_in),
        .rise (intr_edge)
    );

    // Outputs are registered: each transition loads the outputs of the
    // state being entered. Pulse outputs default to 0 every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            pending          <= 1'b0;
            in_service       <= 1'b0;
            flush            <= 1'b0;
            stall            <= 1'b0;
            pc_load          <= 1'b0;
            pc_load_val      <= 8'h00;
            copy_ccr         <= 1'b0;
            paste_ccr        <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr_sel <= SEL_PUSH;
            bus.mem_wdata    <= 8'h00;
        end else begin
            // A fresh edge during FLUSH is a new request and must survive.
            if (intr_edge)
                pending <= 1'b1;
            else if (state == ST_FLUSH)
                pending <= 1'b0;

            flush       <= 1'b0;
            copy_ccr    <= 1'b0;
            paste_ccr   <= 1'b0;
            pc_load     <= 1'b0;
            pc_load_val <= 8'h00;

            case (state)
                ST_IDLE: begin
                    if (rti_dec && in_service) begin
                        state            <= ST_POP;
                        stall            <= 1'b1;
                        bus.mem_req      <= 1'b1;
                        bus.mem_we       <= 1'b0;
                        bus.mem_addr_sel <= SEL_POP;
                    end else if (pending && !in_service && !rti_dec) begin
                        state    <= ST_FLUSH;
                        stall    <= 1'b1;
                        flush    <= 1'b1;
                        copy_ccr <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state            <= ST_PUSH;
                    in_service       <= 1'b1;
                    bus.mem_req      <= 1'b1;
                    bus.mem_we       <= 1'b1;
                    bus.mem_addr_sel <= SEL_PUSH;
                    bus.mem_wdata    <= pc_ret;
                end
                ST_PUSH: begin
                    if (bus.mem_ack) begin
                        state            <= ST_VEC;
                        bus.mem_we       <= 1'b0;
                        bus.mem_addr_sel <= SEL_VEC;
                        bus.mem_wdata    <= 8'h00;
                    end
                end
                ST_VEC: begin
                    if (bus.mem_ack) begin
                        state            <= ST_JUMP;
                        bus.mem_req      <= 1'b0;
                        bus.mem_addr_sel <= SEL_PUSH;
                        pc_load          <= 1'b1;
                        pc_load_val      <= bus.mem_rdata;
                    end
                end
                ST_JUMP: begin
                    state <= ST_IDLE;
                    stall <= 1'b0;
                end
                ST_POP: begin
                    if (bus.mem_ack) begin
                        state            <= ST_RESUME;
                        bus.mem_req      <= 1'b0;
                        bus.mem_addr_sel <= SEL_PUSH;
                        pc_load          <= 1'b1;
                        pc_load_val      <= bus.mem_rdata;
                        paste_ccr        <= 1'b1;
                    end
                end
                ST_RESUME: begin
                    state      <= ST_IDLE;
                    stall      <= 1'b0;
                    in_service <= 1'b0;
                end
                default: begin
                    state            <= ST_IDLE;
                    stall            <= 1'b0;
                    bus.mem_req      <= 1'b0;
                    bus.mem_we       <= 1'b0;
                    bus.mem_addr_sel <= SEL_PUSH;
                    bus.mem_wdata    <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl
// Directed self-checking bench for int_ctrl. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr_in;
    logic       rti_dec;
    logic [7:0] pc_ret;
    logic       flush;
    logic       stall;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       copy_ccr;
    logic       paste_ccr;
    logic       in_service;

    int n_chk = 0;
    int n_err = 0;
    int flush_cnt = 0;
    int load_cnt  = 0;
    int ccr_cnt   = 0;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .intr_in     (intr_in),
        .rti_dec     (rti_dec),
        .pc_ret      (pc_ret),
        .bus         (bus),
        .flush       (flush),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .copy_ccr    (copy_ccr),
        .paste_ccr   (paste_ccr),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;

    // Count pulse cycles at the rising edge (pre-edge values).
    always @(posedge clk) begin
        if (flush)   flush_cnt <= flush_cnt + 1;
        if (pc_load) load_cnt  <= load_cnt + 1;
        if (copy_ccr || paste_ccr) ccr_cnt <= ccr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, flush, stall, pc_load, pc_load_val, copy_ccr, paste_ccr,
                in_service, bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.mem_wdata};
    endfunction

    // Drop intr_in long enough to clear the synchronizer, then raise it.
    task automatic pulse_edge();
        intr_in = 1'b0;
        repeat (3) tick();
        intr_in = 1'b1;
    endtask

    task automatic wait_flush(input string tag);
        int n = 0;
        while (flush !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, flush, 1);
    endtask

    int c0;
    int l0;
    int k0;

    initial begin
        rst = 1'b1; intr_in = 1'b0; rti_dec = 1'b0; pc_ret = 8'h00;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        repeat (3) tick();
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), 0);

        // RTI outside service is ignored
        rti_dec = 1'b1; tick(); rti_dec = 1'b0;
        check("rti_ignored", {bus.mem_req, stall}, 2'b00);

        // Interrupt entry
        pc_ret = 8'h3C; bus.mem_ack = 1'b1; bus.mem_rdata = 8'h80; intr_in = 1'b1;
        wait_flush("entry_flush");
        check("entry_copy", copy_ccr, 1);
        check("entry_stall", {stall, bus.mem_req}, 2'b10);
        tick();
        check("push_req", {bus.mem_req, bus.mem_we, bus.mem_addr_sel}, 4'b1100);
        check("push_wdata", bus.mem_wdata, 8'h3C);
        check("push_in_service", in_service, 1);
        check("copy_single_pulse", copy_ccr, 0);
        tick();
        check("vec_req", {bus.mem_req, bus.mem_we, bus.mem_addr_sel}, 4'b1010);
        tick();
        check("jump_load", {pc_load, pc_load_val}, {1'b1, 8'h80});
        check("jump_no_req", bus.mem_req, 0);
        tick();
        check("handler_idle", {stall, pc_load, in_service}, 3'b001);

        // Two more edges during the handler: held pending, no nested entry
        c0 = flush_cnt;
        pulse_edge();
        pulse_edge();
        repeat (6) tick();
        check("nested_flush_blocked", flush_cnt - c0, 0);

        // Return from interrupt
        bus.mem_rdata = 8'h3C; pc_ret = 8'h55;
        rti_dec = 1'b1; tick(); rti_dec = 1'b0;
        check("pop_req", {bus.mem_req, bus.mem_we, bus.mem_addr_sel}, 4'b1001);
        check("pop_stall", stall, 1);
        tick();
        check("resume_load", {pc_load, pc_load_val}, {1'b1, 8'h3C});
        check("resume_paste", {paste_ccr, copy_ccr}, 2'b10);
        tick();
        check("resume_idle", {stall, in_service, paste_ccr}, 3'b000);
        bus.mem_rdata = 8'h80;
        tick();
        check("pending_flush", {flush, copy_ccr}, 2'b11);
        tick();
        check("push2_wdata", bus.mem_wdata, 8'h55);
        tick(); tick();
        check("jump2_load", {pc_load, pc_load_val}, {1'b1, 8'h80});
        tick();
        c0 = flush_cnt;
        repeat (10) tick();
        check("edges_collapsed", flush_cnt - c0, 0);

        // Pending set while RTI arrives: pop first, then service
        pulse_edge();
        repeat (4) tick();
        bus.mem_rdata = 8'h44;
        rti_dec = 1'b1; tick(); rti_dec = 1'b0;
        check("tie_pop_first", {flush, bus.mem_req, bus.mem_addr_sel}, 4'b0101);
        tick();
        check("tie_resume", {pc_load, pc_load_val, paste_ccr}, {1'b1, 8'h44, 1'b1});
        pc_ret = 8'h66; bus.mem_rdata = 8'h90;
        tick();
        tick();
        check("tie_serviced_flush", flush, 1);
        tick(); tick(); tick();
        check("tie_jump", {pc_load, pc_load_val}, {1'b1, 8'h90});
        tick();

        // Slow memory, then reset mid-sequence
        intr_in = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        pulse_edge();
        wait_flush("slow_flush");
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("push_hold_%0d", i),
                  {bus.mem_req, bus.mem_we, stall, bus.mem_addr_sel}, 5'b11100);
            tick();
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("vec_wait", {bus.mem_req, bus.mem_addr_sel}, 3'b110);
        tick();
        check("vec_hold", {bus.mem_req, bus.mem_addr_sel, stall}, 4'b1101);
        l0 = load_cnt; k0 = ccr_cnt;
        rst = 1'b1; intr_in = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5;
        tick();
        check("rst_in_vec_outs", outs(), 0);
        rst = 1'b0; bus.mem_ack = 1'b0;
        repeat (5) tick();
        check("rst_no_load", load_cnt - l0, 0);
        check("rst_no_ccr", ccr_cnt - k0, 0);
        check("rst_idle_outs", outs(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have clk, input, 1: rising-edge clock.
REQ-002 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have intr_in, input, 1: external interrupt request, asynchronous to clk.
REQ-004 SHALL have rti_dec, input, 1: one-cycle pulse, RTI decoded in execute.
REQ-005 SHALL have pc_ret, input, 8: return PC captured at interrupt entry.
REQ-006 SHALL have mem_req / mem_we, output, 1 each: stack/vector memory request; mem_we=1 for push.
REQ-007 SHALL have mem_addr_sel, output, 2: 0 = SP-push, 1 = SP-pop, 2 = vector address VEC_ADDR.
REQ-008 SHALL have mem_wdata, output, 8: data pushed (latched return PC).
REQ-009 SHALL have mem_ack, input, 1 and mem_rdata, input, 8: memory completion and read data.
REQ-010 SHALL have flush, output, 1: clears IF/ID/EX pipeline registers.
REQ-011 SHALL have stall, output, 1: freezes PC and fetch while the block is not IDLE.
REQ-012 SHALL have pc_load, output, 1 and pc_load_val, output, 8: one-cycle PC override.
REQ-013 SHALL have copy_ccr and paste_ccr, output, 1 each: CCR backup and restore pulses.
REQ-014 SHALL have in_service, output, 1: handler active, further interrupts masked.

Function
REQ-015 SHALL pass intr_in through a 2-flop synchronizer, then detect rising edges; each edge sets a pending bit.
REQ-016 SHALL implement states IDLE, FLUSH, PUSH, VEC, JUMP, POP and RESUME.
REQ-017 IDLE -> POP when rti_dec=1 and in_service=1; rti_dec with in_service=0 SHALL be ignored.
REQ-018 IDLE -> FLUSH when pending=1, in_service=0 and rti_dec=0; RTI SHALL win a same-cycle tie, and pending SHALL stay set.
REQ-019 FLUSH (1 cycle) SHALL assert flush=1 and copy_ccr=1, latch pc_ret, clear pending and set in_service.
REQ-020 PUSH SHALL hold mem_req=1, mem_we=1, mem_addr_sel=0 and mem_wdata=the latched PC until mem_ack, then go to VEC.
REQ-021 VEC SHALL hold mem_req=1, mem_we=0, mem_addr_sel=2 until mem_ack, latching mem_rdata as the target.
REQ-022 JUMP (1 cycle) SHALL assert pc_load=1 with pc_load_val=target, then go to IDLE.
REQ-023 POP SHALL hold mem_req=1, mem_we=0, mem_addr_sel=1 until mem_ack, latching mem_rdata.
REQ-024 RESUME (1 cycle) SHALL assert pc_load=1 with the popped PC and paste_ccr=1, clear in_service, then go to IDLE.
REQ-025 copy_ccr and paste_ccr SHALL never be asserted in the same cycle; each SHALL be a single-cycle pulse.
REQ-026 stall SHALL be 1 in every state except IDLE; mem_req SHALL be 0 outside PUSH, VEC and POP.
REQ-027 Edges arriving while in_service=1 SHALL set pending and SHALL be serviced only after RESUME; multiple edges SHALL collapse into one.
REQ-028 No timeout on mem_ack; the FSM SHALL wait indefinitely.

Reset
REQ-029 rst SHALL force IDLE and clear pending, in_service, the synchronizer flops and the latches.
REQ-030 During and after rst every output SHALL be 0, including mem_addr_sel=0 and pc_load_val=0.
REQ-031 rst mid-sequence SHALL abort the sequence with no further copy_ccr, paste_ccr or pc_load.

Structure
REQ-032 Shared package SHALL hold the state enum, VEC_ADDR=8'h01 and the mem_addr_sel encodings.
REQ-033 SHALL contain one sub-module, sync_edge (2-flop synchronizer plus rising-edge detector); the rest is inline.

Verification
REQ-034 intr_in rises, pc_ret=8'h3C, mem_ack=1 on first request, mem_rdata=8'h80 -> flush+copy_ccr in one cycle, push wdata=8'h3C, then pc_load=1 with val 8'h80, in_service=1.
REQ-035 In service, rti_dec pulse, pop returns 8'h3C -> pc_load val 8'h3C with paste_ccr=1 in the same cycle, in_service=0, then IDLE.
REQ-036 Second intr_in edge during handler -> no flush until RESUME, then a new FLUSH occurs within 2 cycles of IDLE.
REQ-037 rti_dec and pending both set in IDLE -> POP taken first, and the interrupt is serviced next.
REQ-038 mem_ack withheld for 5 cycles in PUSH -> mem_req and stall held steady; rst asserted in VEC -> IDLE next cycle, all outputs 0, no pc_load.
